// File: rtl/user_counters_pkg.sv
// Shared definitions for the user-area counter block: register indices,
// CTRL/STAT bit positions, the Wishbone ack FSM state type and a byte-mask helper.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

package user_counters_pkg;

  // Register index within a channel window (byte offset = index * 4).
  localparam logic [1:0] REG_CNT  = 2'd0;  // +0x0
  localparam logic [1:0] REG_CMP  = 2'd1;  // +0x4
  localparam logic [1:0] REG_CTRL = 2'd2;  // +0x8
  localparam logic [1:0] REG_STAT = 2'd3;  // +0xC

  // CTRL bit positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_DOWN   = 3;
  localparam int CTRL_BITS   = 4;

  // STAT bit positions.
  localparam int STAT_MATCH = 0;

  // Wishbone acknowledge FSM.
  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_e;

  // Expand the four Wishbone byte enables into a 32-bit bit mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/user_counter_channel.sv
// One programmable counter channel: CNT/CMP/CTRL/STAT registers, up/down
// counting with optional auto-reload, sticky MATCH flag.
// CNT next-value priority: bus write > LA per-bit override > count update.
module user_counter_channel
  import user_counters_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,    // one-cycle write strobe for this channel
  input  logic [1:0]           wr_reg_i,   // register index being written
  input  logic [31:0]          wr_data_i,
  input  logic [3:0]           wr_sel_i,
  input  logic [WIDTH-1:0]     la_mask_i,  // 1 = bit is driven from la_val_i
  input  logic [WIDTH-1:0]     la_val_i,
  output logic [WIDTH-1:0]     cnt_o,
  output logic [WIDTH-1:0]     cmp_o,
  output logic [CTRL_BITS-1:0] ctrl_o,
  output logic                 match_o,
  output logic                 hit_o       // compare condition this cycle
);

  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     cmp_q, cmp_d;
  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic                 match_q, match_d;

  logic [31:0]          byte_mask;
  logic [WIDTH-1:0]     wmask;
  logic [CTRL_BITS-1:0] cmask;
  logic                 en, reload, down, hit;
  logic [WIDTH-1:0]     count_next;
  logic [WIDTH-1:0]     la_merged;

  assign byte_mask = sel_to_mask(wr_sel_i);
  assign wmask     = byte_mask[WIDTH-1:0];
  assign cmask     = byte_mask[CTRL_BITS-1:0];

  assign en     = ctrl_q[CTRL_EN];
  assign reload = ctrl_q[CTRL_RELOAD];
  assign down   = ctrl_q[CTRL_DOWN];

  // Up mode compares against CMP, down mode against zero; disabled never hits.
  assign hit = en & (down ? (cnt_q == '0) : (cnt_q == cmp_q));

  // Next-state for all channel registers, lowest priority source first.
  always_comb begin
    count_next = cnt_q;
    if (en) begin
      if (down) begin
        count_next = (hit && reload) ? cmp_q : cnt_q - WIDTH'(1);
      end else begin
        count_next = (hit && reload) ? '0 : cnt_q + WIDTH'(1);
      end
    end

    la_merged = (count_next & ~la_mask_i) | (la_val_i & la_mask_i);

    cnt_d   = la_merged;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    match_d = match_q;

    if (wr_en_i) begin
      case (wr_reg_i)
        REG_CNT:  cnt_d  = (la_merged & ~wmask) | (wr_data_i[WIDTH-1:0] & wmask);
        REG_CMP:  cmp_d  = (cmp_q & ~wmask) | (wr_data_i[WIDTH-1:0] & wmask);
        REG_CTRL: ctrl_d = (ctrl_q & ~cmask) | (wr_data_i[CTRL_BITS-1:0] & cmask);
        REG_STAT: begin
          if (wr_sel_i[0] && wr_data_i[STAT_MATCH]) begin
            match_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A new hit in the same cycle as a clear keeps MATCH set.
    if (hit) begin
      match_d = 1'b1;
    end
  end

  // Channel register bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = ctrl_q;
  assign match_o = match_q;
  assign hit_o   = hit;

  logic unused_ok;
  assign unused_ok = &{1'b0, wr_data_i, byte_mask, 1'b0};

endmodule

// File: rtl/user_proj_counters.sv
// Caravel user-area peripheral: NUM_CH programmable counters on the
// management Wishbone port, with channel 0 preloadable from the logic
// analyzer and mirrored on LA and GPIO outputs.
//
// Bus handshake: a request is stb & cyc & base-window hit while the FSM is
// idle; it is accepted on that clock edge (writes commit there, read data is
// captured there) and wbs_ack_o is high for exactly the following cycle, with
// wbs_dat_o valid only while ack is high. The cycle after ack never accepts,
// so back-to-back requests are acked every other cycle. Requests outside the
// base window are never acked.
module user_proj_counters
  import user_counters_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IO_BITS   = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  input  logic [127:0]              la_data_in,
  input  logic [127:0]              la_oenb,
  output logic [127:0]              la_data_out,
  output logic [`MPRJ_IO_PADS-1:0]  io_out,
  output logic [`MPRJ_IO_PADS-1:0]  io_oeb,
  output logic [2:0]                user_irq
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       addr_hit, req, accept;
  logic [3:0] ch_idx;
  logic [1:0] reg_idx;

  assign addr_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req      = wbs_stb_i & wbs_cyc_i & addr_hit;
  assign ch_idx   = wbs_adr_i[7:4];
  assign reg_idx  = wbs_adr_i[3:2];

  // ---------------------------------------------------------------------------
  // Ack FSM (state kept in wb_state_q for observation)
  // ---------------------------------------------------------------------------
  wb_state_e   wb_state_q, wb_state_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rd_data;

  assign accept = (wb_state_q == WB_IDLE) & req;

  // Ack state and read-data register; reset drops an in-flight ack at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_state_q <= WB_IDLE;
      dat_q      <= '0;
    end else begin
      wb_state_q <= wb_state_d;
      dat_q      <= dat_d;
    end
  end

  // Next state: IDLE -> ACK on an accepted request, ACK -> IDLE always.
  always_comb begin
    wb_state_d = wb_state_q;
    dat_d      = '0;
    case (wb_state_q)
      WB_IDLE: begin
        if (req) begin
          wb_state_d = WB_ACK;
          if (!wbs_we_i) begin
            dat_d = rd_data;
          end
        end
      end
      WB_ACK:  wb_state_d = WB_IDLE;
      default: wb_state_d = WB_IDLE;
    endcase
  end

  assign wbs_ack_o = (wb_state_q == WB_ACK);
  assign wbs_dat_o = dat_q;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]     cnt_a  [NUM_CH];
  logic [WIDTH-1:0]     cmp_a  [NUM_CH];
  logic [CTRL_BITS-1:0] ctrl_a [NUM_CH];
  logic [NUM_CH-1:0]    match_v;
  logic [NUM_CH-1:0]    hit_v;
  logic [NUM_CH-1:0]    irq_src;

  logic [WIDTH-1:0] la_mask;
  logic [WIDTH-1:0] la_val;

  // LA bit i drives ch0 CNT bit i when its enable (active-low) at 32+i is 0.
  assign la_mask = ~la_oenb[32 +: WIDTH];
  assign la_val  = la_data_in[WIDTH-1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             wr_en_c;
    logic [WIDTH-1:0] la_mask_c;

    // Channel indices >= NUM_CH match no channel, so those writes are dropped.
    assign wr_en_c   = accept & wbs_we_i & (ch_idx == 4'(c));
    assign la_mask_c = (c == 0) ? la_mask : '0;

    user_counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i     (wb_clk_i),
      .rst_ni    (wb_rst_ni),
      .wr_en_i   (wr_en_c),
      .wr_reg_i  (reg_idx),
      .wr_data_i (wbs_dat_i),
      .wr_sel_i  (wbs_sel_i),
      .la_mask_i (la_mask_c),
      .la_val_i  (la_val),
      .cnt_o     (cnt_a[c]),
      .cmp_o     (cmp_a[c]),
      .ctrl_o    (ctrl_a[c]),
      .match_o   (match_v[c]),
      .hit_o     (hit_v[c])
    );

    assign irq_src[c] = match_v[c] & ctrl_a[c][CTRL_IRQ_EN];
  end

  // Read mux: zero-extended register of the addressed channel, 0 when unmapped.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == 4'(c)) begin
        case (reg_idx)
          REG_CNT:  rd_data[WIDTH-1:0]     = cnt_a[c];
          REG_CMP:  rd_data[WIDTH-1:0]     = cmp_a[c];
          REG_CTRL: rd_data[CTRL_BITS-1:0] = ctrl_a[c];
          REG_STAT: rd_data[STAT_MATCH]    = match_v[c];
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt: one-cycle registered OR of enabled MATCH flags
  // ---------------------------------------------------------------------------
  logic irq_q;

  // Registered interrupt request.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_src;
    end
  end

  assign user_irq = {2'b00, irq_q};

  // ---------------------------------------------------------------------------
  // LA / GPIO mirror of channel 0 (combinational from the CNT register)
  // ---------------------------------------------------------------------------
  logic [63:0] cnt0_ext;

  // Zero-extend ch0 CNT and map it onto LA and the low GPIO pads.
  always_comb begin
    cnt0_ext                = '0;
    cnt0_ext[WIDTH-1:0]     = cnt_a[0];
    la_data_out             = '0;
    la_data_out[WIDTH-1:0]  = cnt_a[0];
    io_out                  = '0;
    io_out[IO_BITS-1:0]     = cnt0_ext[IO_BITS-1:0];
    io_oeb                  = '1;
    io_oeb[IO_BITS-1:0]     = '0;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], la_data_in, la_oenb, cnt0_ext, hit_v, 1'b0};

endmodule

// File: tb/tb_user_proj_counters.sv
// Directed bench for user_proj_counters: bus transactions push their expected
// read data into a queue, a negedge monitor pops and compares on every ack.
module tb_user_proj_counters;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          PADS = `MPRJ_IO_PADS;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i, wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic [127:0]     la_data_in, la_oenb, la_data_out;
  logic [PADS-1:0]  io_out, io_oeb;
  logic [2:0]       user_irq;

  always #5 clk = ~clk;

  user_proj_counters dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .user_irq    (user_irq)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       name_q[$];

  logic [31:0] mon_exp;
  bit          mon_chk;
  string       mon_name;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor: every ack consumes one queued transaction.
  always @(negedge clk) begin
    if (rst_n && wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got ack with data %h, expected no ack", wbs_dat_o);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_chk  = chk_q.pop_front();
        mon_name = name_q.pop_front();
        if (mon_chk) check(mon_name, wbs_dat_o, mon_exp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ra(input int ch, input int r);
    return BASE + 32'(ch * 16 + r * 4);
  endfunction

  task automatic bus_idle();
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit chk, input logic [31:0] expv,
                         input string name);
    int n;
    exp_q.push_back(expv);
    chk_q.push_back(chk);
    name_q.push_back(name);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    n = 0;
    do begin
      step();
      n++;
    end while (!wbs_ack_o && n < 8);
    if (!wbs_ack_o) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout_%s: got no ack in %0d cycles, expected ack", name, n);
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
      void'(name_q.pop_back());
    end
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_xfer(1'b1, adr, dat, sel, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] expv, input string name);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, 1'b1, expv, name);
  endtask

  // Out-of-window request must never be acked.
  task automatic wb_miss(input logic [31:0] adr, input string name);
    logic seen;
    seen = 1'b0;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = adr;
    wbs_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wbs_ack_o) seen = 1'b1;
    end
    bus_idle();
    check(name, 32'(seen), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [PADS-1:0] e_oeb;

  initial begin
    bus_idle();
    la_data_in = '0;
    la_oenb    = '1;
    e_oeb      = '1;
    e_oeb[15:0] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_irq", 32'(user_irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd(ra(1, 0), 32'h0, "rst_cnt1");
    rd(ra(2, 2), 32'h0, "rst_ctrl2");
    rd(ra(3, 3), 32'h0, "rst_stat3");
    check_w("io_oeb", 128'(io_oeb), 128'(e_oeb));

    // Up count with reload on ch1 (accepts every other cycle: E, E+2, ...)
    wr(ra(1, 1), 32'd5, 4'hF);
    wr(ra(1, 2), 32'h3, 4'hF);             // EN|RELOAD, count 0 from here
    rd(ra(1, 0), 32'd1, "up_cnt_a");
    rd(ra(1, 0), 32'd3, "up_cnt_b");
    rd(ra(1, 3), 32'd0, "up_stat_before");
    rd(ra(1, 3), 32'd1, "up_stat_after");
    rd(ra(1, 0), 32'd3, "up_cnt_reloaded");
    wr(ra(1, 2), 32'h0, 4'hF);
    rd(ra(1, 0), 32'd0, "up_cnt_stopped");

    // Down count without reload on ch2, wrap and W1C
    wr(ra(2, 0), 32'd2, 4'hF);
    wr(ra(2, 2), 32'h9, 4'hF);             // EN|DOWN
    rd(ra(2, 0), 32'd1, "dn_cnt_a");
    rd(ra(2, 0), 32'hFFFF_FFFF, "dn_cnt_wrap");
    wr(ra(2, 2), 32'h0, 4'hF);
    rd(ra(2, 3), 32'd1, "dn_stat_set");
    wr(ra(2, 3), 32'h1, 4'h1);
    rd(ra(2, 3), 32'd0, "dn_stat_cleared");
    rd(ra(2, 0), 32'hFFFF_FFFC, "dn_cnt_held");

    // IRQ on ch0, CMP=3, EN|RELOAD|IRQ_EN
    wr(ra(0, 1), 32'd3, 4'hF);
    wr(ra(0, 2), 32'h7, 4'hF);
    check_w("irq_cnt0", la_data_out, 128'd0);
    step();
    check_w("irq_cnt1", la_data_out, 128'd1);
    step(); step(); step();
    check_w("irq_cnt_reload", la_data_out, 128'd0);
    check("irq_latency_lo", 32'(user_irq), 32'h0);
    step();
    check("irq_set", 32'(user_irq), 32'h1);
    step(); step();
    check_w("irq_cnt3", la_data_out, 128'd3);
    wr(ra(0, 3), 32'h1, 4'h1);             // clear lands on the next hit edge
    check("irq_w1c_hit_a", 32'(user_irq), 32'h1);
    step();
    check("irq_w1c_hit_b", 32'(user_irq), 32'h1);
    rd(ra(0, 3), 32'd1, "irq_stat_kept");

    // LA override on ch0 low byte, bus write wins
    wr(ra(0, 2), 32'h1, 4'hF);             // EN only
    la_oenb[39:32]  = 8'h00;
    la_data_in[7:0] = 8'hA5;
    step();
    check("la_cnt_byte", 32'(la_data_out[7:0]), 32'hA5);
    check("la_io_byte", 32'(io_out[7:0]), 32'hA5);
    wr(ra(0, 0), 32'h0000_1234, 4'hF);
    check_w("la_wb_wins", la_data_out, 128'h1234);
    check("la_io_wb", 32'(io_out[15:0]), 32'h1234);
    check("la_io_hi", 32'(io_out[PADS-1:16]), 32'h0);
    step();
    check_w("la_next", la_data_out, 128'h12A5);
    la_oenb = '1;
    wr(ra(0, 2), 32'h0, 4'hF);

    // Bus byte enables, CTRL masking, unmapped offsets, misses
    wr(ra(3, 1), 32'hFFFF_FFFF, 4'b0010);
    rd(ra(3, 1), 32'h0000_FF00, "sel_cmp3");
    wr(ra(3, 0), 32'h1234_56AB, 4'b0001);
    rd(ra(3, 0), 32'h0000_00AB, "sel_cnt3");
    wr(ra(3, 2), 32'hFFFF_FFF6, 4'hF);
    rd(ra(3, 2), 32'h0000_0006, "ctrl_bits");
    wr(ra(3, 2), 32'h0, 4'hF);
    wr(BASE + 32'h80, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'h80, 32'h0, "oob_read");
    rd(BASE + 32'hF4, 32'h0, "oob_read_hi");
    rd(ra(0, 1), 32'd3, "no_alias_cmp0");
    wb_miss(BASE + 32'h100, "miss_next_window");
    wb_miss(32'h2000_0000, "miss_other_base");

    // Reset during a read
    wr(ra(0, 2), 32'h4, 4'hF);             // IRQ_EN with MATCH still set
    step();
    check("pre_rst_irq", 32'(user_irq), 32'h1);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_adr_i = ra(1, 1);
    wbs_sel_i = 4'hF;
    step();
    check("midread_ack", 32'(wbs_ack_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midread_ack_drop", 32'(wbs_ack_o), 32'h0);
    check("midread_dat", wbs_dat_o, 32'h0);
    check("midread_irq", 32'(user_irq), 32'h0);
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(ra(c, r), 32'h0, $sformatf("post_rst_c%0d_r%0d", c, r));
      end
    end
    check_w("post_rst_la", la_data_out, 128'd0);
    check("post_rst_irq", 32'(user_irq), 32'h0);

    step(); step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
